// File: rtl/disp_scan_ctrl_if.sv
// disp_scan_ctrl_if
//   Bundles the user-side write/commit bus and the display-side scan outputs
//   of disp_scan_ctrl.
//   master : user logic / testbench. Drives we, waddr, wdata, commit and
//            en_mask. Observes sel, dig, seg, frame and pending.
//   slave  : disp_scan_ctrl itself.
//   Signals:
//     we       shadow write strobe
//     waddr    digit index to write (0 = rightmost)
//     wdata    hex value 0x0..0xF
//     commit   one-cycle request to copy shadow to active at the next frame wrap
//     en_mask  live per-digit enable (bit i = 0 blanks digit i)
//     sel      current digit slot index
//     dig      active-low digit strobes
//     seg      active-low segments {g,f,e,d,c,b,a}
//     frame    one-cycle pulse in the first cycle of slot 0
//     pending  a commit is waiting for the next frame wrap
interface disp_scan_ctrl_if;
  logic       we;
  logic [2:0] waddr;
  logic [3:0] wdata;
  logic       commit;
  logic [7:0] en_mask;
  logic [2:0] sel;
  logic [7:0] dig;
  logic [6:0] seg;
  logic       frame;
  logic       pending;

  modport master (
    output we, waddr, wdata, commit, en_mask,
    input  sel, dig, seg, frame, pending
  );

  modport slave (
    input  we, waddr, wdata, commit, en_mask,
    output sel, dig, seg, frame, pending
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
//   Scan controller for an 8-digit multiplexed seven-segment display.
//   Eight 4-bit digits live in a shadow/active register pair: writes land in
//   shadow, and a commit copies shadow to active only at a frame wrap so a
//   half-updated number is never shown. Each digit slot lasts DIV clocks,
//   the first of which is a dead-time cycle with every strobe off.
//
//   Parameter:
//     DIV      clocks per digit slot (2..65535), 16-bit prescaler
//   Ports:
//     clk      system clock, rising edge
//     rst_n    asynchronous active-low reset
//     bus      disp_scan_ctrl_if.slave (write/commit inputs, scan outputs)
//
//   Optional feature macro:
//     DISP_LZB_EN  when defined, leading zeros of the active value are blanked
//                  (digit 0 always stays visible).
module disp_scan_ctrl #(
  parameter int unsigned DIV = 1024
) (
  input logic            clk,
  input logic            rst_n,
  disp_scan_ctrl_if.slave bus
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0]     cnt_reg, cnt_next;
  logic [2:0]      sel_reg, sel_next;
  logic            pending_reg, pending_next;
  logic            frame_reg;
  logic [7:0]      dig_reg, dig_next;
  logic [6:0]      seg_reg, seg_next;
  logic [7:0][3:0] shadow_reg;
  logic [7:0][3:0] active_reg, active_next;
  logic [7:0]      visible;
  logic            tick, frame_tick, copy;

  // Active-low {g,f,e,d,c,b,a}; b and d use the lowercase glyphs.
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= 16'd0;
      sel_reg     <= 3'd0;
      pending_reg <= 1'b0;
      frame_reg   <= 1'b0;
      dig_reg     <= 8'hFF;
      seg_reg     <= 7'h7F;
      shadow_reg  <= '0;
      active_reg  <= '0;
    end else begin
      cnt_reg     <= cnt_next;
      sel_reg     <= sel_next;
      pending_reg <= pending_next;
      frame_reg   <= frame_tick;
      dig_reg     <= dig_next;
      seg_reg     <= seg_next;
      active_reg  <= active_next;
      if (bus.we) begin
        shadow_reg[bus.waddr] <= bus.wdata;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    tick         = (cnt_reg == LAST);
    frame_tick   = tick && (sel_reg == 3'd7);
    copy         = frame_tick && pending_reg;
    cnt_next     = tick ? 16'd0 : cnt_reg + 16'd1;
    sel_next     = tick ? sel_reg + 3'd1 : sel_reg;
    // A commit arriving on the frame tick itself wins over the clear, so it
    // waits for the following frame.
    pending_next = bus.commit || (pending_reg && !frame_tick);
  end

  // The copy reads shadow_reg before this edge's write lands, so a write in
  // the frame-tick cycle stays in shadow for the next commit.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      assign active_next[gi] = copy ? shadow_reg[gi] : active_reg[gi];
    end
  endgenerate

`ifdef DISP_LZB_EN
  // zero_from[i] is high when digit i and every digit above it are zero.
  logic [8:1] zero_from;
  assign zero_from[8] = 1'b1;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_lzb
      assign zero_from[gi] = (active_next[gi] == 4'd0) && zero_from[gi + 1];
    end
  endgenerate
  assign visible = bus.en_mask & ~{zero_from[7:1], 1'b0};
`else
  assign visible = bus.en_mask;
`endif

  // ---------------------------------------------------------------------
  // Output logic: evaluated on the next state so the registered strobes
  // line up with the sel/cnt of the same cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    dig_next = 8'hFF;
    seg_next = 7'h7F;
    if ((cnt_next != 16'd0) && visible[sel_next]) begin
      dig_next = ~(8'd1 << sel_next);
      seg_next = hex_glyph(active_next[sel_next]);
    end
  end

  assign bus.sel     = sel_reg;
  assign bus.dig     = dig_reg;
  assign bus.seg     = seg_reg;
  assign bus.frame   = frame_reg;
  assign bus.pending = pending_reg;

endmodule
